// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, idle line level and the
// transmitter state encoding. The SoC-side decoder imports this too.
package uart_pkg;

  // Data bits per frame (LSB first on the wire).
  localparam int UART_DATA_BITS = 8;

  // Width of the bit index that walks the data bits.
  localparam int UART_BIT_IDX_W = $clog2(UART_DATA_BITS);

  // Level of the serial line between frames; also the stop-bit level.
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Transmitter frame states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head output.
// Full/empty come from the occupancy count so that wrapped pointers
// never make a full buffer look empty. A push into a full FIFO is
// dropped even if a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (level_reg == LEVEL_FULL);
  assign empty   = (level_reg == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr_reg];
  assign level   = level_reg;

  // Storage write; contents need no reset because occupancy gates reads.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap modulo DEPTH.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_stim.sv
// Host-side UART transmitter driving the SoC's externalPins_uart_rx.
// Bytes enter through a valid/ready FIFO and leave as 8N1/8N2 frames,
// LSB first. Frames are chained with no idle gap while data is queued;
// the line rests at the idle level otherwise.
module uart_tx_stim
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  // The counter must reach the end of the longest cell, the stop period.
  localparam int BAUD_W = $clog2(CLKS_PER_BIT * STOP_BITS);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [UART_BIT_IDX_W-1:0] LAST_BIT_IDX = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

  uart_state_e                 state_reg,   state_next;
  logic [BAUD_W-1:0]           baud_reg,    baud_next;
  logic [UART_BIT_IDX_W-1:0]   bit_idx_reg, bit_idx_next;
  logic [UART_DATA_BITS-1:0]   shift_reg,   shift_next;
  logic                        tx_reg,      tx_next;
  logic                        tx_done_reg, tx_done_next;

  logic                        fifo_push;
  logic                        fifo_pop;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [UART_DATA_BITS-1:0]   fifo_head;
  logic                        bit_end;
  logic                        stop_end;

  // Ready is withheld during reset so nothing is pushed into a FIFO that
  // is being cleared.
  assign in_ready  = !fifo_full && !reset;
  assign fifo_push = in_valid && in_ready;

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign bit_end  = (baud_reg == BIT_LAST);
  assign stop_end = (baud_reg == STOP_LAST);

  // Frame sequencing. tx_next is the line level for the coming cycle, so
  // the line changes on the same edge as the state it belongs to.
  always_comb begin
    state_next   = state_reg;
    baud_next    = baud_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    tx_next      = tx_reg;
    tx_done_next = 1'b0;
    fifo_pop     = 1'b0;

    case (state_reg)
      IDLE: begin
        tx_next = UART_IDLE_LEVEL;
        if (!fifo_empty) begin
          fifo_pop     = 1'b1;
          shift_next   = fifo_head;
          baud_next    = '0;
          bit_idx_next = '0;
          tx_next      = 1'b0;
          state_next   = START;
        end
      end

      START: begin
        if (bit_end) begin
          baud_next    = '0;
          bit_idx_next = '0;
          tx_next      = shift_reg[0];
          state_next   = DATA;
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end

      DATA: begin
        if (bit_end) begin
          baud_next  = '0;
          shift_next = {1'b0, shift_reg[UART_DATA_BITS-1:1]};
          if (bit_idx_reg == LAST_BIT_IDX) begin
            tx_next    = UART_IDLE_LEVEL;
            state_next = STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 1'b1;
            // Next bit to send is the one that lands in shift[0].
            tx_next      = shift_reg[1];
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end

      STOP: begin
        if (stop_end) begin
          tx_done_next = 1'b1;
          baud_next    = '0;
          if (!fifo_empty) begin
            // Chain straight into the next start bit, no idle cycle.
            fifo_pop     = 1'b1;
            shift_next   = fifo_head;
            bit_idx_next = '0;
            tx_next      = 1'b0;
            state_next   = START;
          end else begin
            tx_next    = UART_IDLE_LEVEL;
            state_next = IDLE;
          end
        end else begin
          baud_next = baud_reg + 1'b1;
        end
      end

      default: begin
        tx_next    = UART_IDLE_LEVEL;
        state_next = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any frame and parks the line idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      tx_reg      <= UART_IDLE_LEVEL;
      tx_done_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      baud_reg    <= baud_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      tx_reg      <= tx_next;
      tx_done_reg <= tx_done_next;
    end
  end

  assign tx      = tx_reg;
  assign tx_done = tx_done_reg;
  assign busy    = (state_reg != IDLE) || (fifo_level != '0);

endmodule

// File: tb/tb_uart_tx_stim.sv
// Directed bench for uart_tx_stim: one 8N1 instance and one 8N2 instance,
// both at 4 clocks per bit. Inputs change and outputs are sampled on the
// falling clock edge.
module tb_uart_tx_stim;

  logic       clock = 1'b0;
  logic       reset;

  logic       a_valid, a_ready, a_tx, a_busy, a_done;
  logic [7:0] a_data;
  logic [4:0] a_level;

  logic       b_valid, b_ready, b_tx, b_busy, b_done;
  logic [7:0] b_data;
  logic [2:0] b_level;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  uart_tx_stim #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16), .STOP_BITS(1)) dut_a (
    .clock(clock), .reset(reset), .in_valid(a_valid), .in_data(a_data),
    .in_ready(a_ready), .tx(a_tx), .busy(a_busy), .tx_done(a_done),
    .fifo_level(a_level)
  );

  uart_tx_stim #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4), .STOP_BITS(2)) dut_b (
    .clock(clock), .reset(reset), .in_valid(b_valid), .in_data(b_data),
    .in_ready(b_ready), .tx(b_tx), .busy(b_busy), .tx_done(b_done),
    .fifo_level(b_level)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Decode one frame whose first start-bit cycle is the current falling edge.
  // Returns the byte (sampled mid-bit), whether start/stop cells held their
  // level throughout, and the offset at which tx_done was first seen.
  // Leaves the bench on the falling edge just after the frame ends.
  task automatic recv(input bit use_b, output logic [7:0] d, output bit ok, output int done_t);
    int   len;
    logic line;
    logic dn;
    len    = use_b ? 44 : 40;
    d      = '0;
    ok     = 1'b1;
    done_t = -1;
    for (int t = 0; t <= len; t++) begin
      if (t > 0) @(negedge clock);
      line = use_b ? b_tx : a_tx;
      dn   = use_b ? b_done : a_done;
      if (t < 4) begin
        if (line !== 1'b0) ok = 1'b0;
      end else if (t < 36) begin
        if ((t % 4) == 2) d[(t - 4) / 4] = line;
      end else if (t < len) begin
        if (line !== 1'b1) ok = 1'b0;
      end
      if (t > 0 && dn === 1'b1 && done_t < 0) done_t = t;
    end
  endtask

  // Advance until the line goes low, at most budget falling edges.
  task automatic wait_low(input bit use_b, input int budget, output bit found);
    int i;
    found = 1'b0;
    i = 0;
    while (!found && i < budget) begin
      if ((use_b ? b_tx : a_tx) === 1'b0) found = 1'b1;
      else begin
        @(negedge clock);
        i++;
      end
    end
  endtask

  logic [7:0] rd, rd2, rd3;
  bit         rok, rok2, rok3, ok3_all, found3, saw_block;
  int         rdt, rdt2, rdt3, max_lvl;
  logic [7:0] acc_q[$];
  logic [7:0] rx_q[$];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b1;
    a_valid = 1'b0; a_data = 8'h00;
    b_valid = 1'b0; b_data = 8'h00;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_tx",    a_tx,    1);
    check("rst_ready", a_ready, 0);
    check("rst_busy",  a_busy,  0);
    check("rst_done",  a_done,  0);
    check("rst_level", a_level, 0);
    check("rst_b_tx",  b_tx,    1);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready", a_ready, 1);
    check("post_rst_tx",    a_tx,    1);

    // Single byte 0x55 from idle
    a_valid = 1'b1; a_data = 8'h55;
    @(negedge clock);
    a_valid = 1'b0;
    check("t1_tx_before", a_tx,    1);
    check("t1_level",     a_level, 1);
    check("t1_busy",      a_busy,  1);
    @(negedge clock);
    check("t1_first_bit", a_tx, 0);
    recv(1'b0, rd, rok, rdt);
    check("t1_byte",      rd,     8'h55);
    check("t1_frame",     rok,    1);
    check("t1_done_at",   rdt,    40);
    check("t1_busy_end",  a_busy, 0);
    check("t1_tx_idle",   a_tx,   1);
    @(negedge clock);
    check("t1_done_pulse", a_done, 0);

    // Back-to-back 0xA5, 0x3C
    a_valid = 1'b1; a_data = 8'hA5;
    @(negedge clock);
    a_data = 8'h3C;
    @(negedge clock);
    a_valid = 1'b0;
    check("t2_level_pushpop", a_level, 1);
    recv(1'b0, rd, rok, rdt);
    recv(1'b0, rd2, rok2, rdt2);
    check("t2_byte0",  rd,   8'hA5);
    check("t2_byte1",  rd2,  8'h3C);
    check("t2_frame0", rok,  1);
    check("t2_frame1", rok2, 1);
    check("t2_done0",  rdt,  40);
    check("t2_done1",  rdt2, 40);
    check("t2_busy_end", a_busy, 0);

    // FIFO full: 20 offered bytes 0x20.., 17 accepted (0x20..0x30)
    max_lvl   = 0;
    saw_block = 1'b0;
    ok3_all   = 1'b1;
    found3    = 1'b0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          a_valid = 1'b1;
          a_data  = 8'(32 + i);
          if (a_ready) acc_q.push_back(a_data);
          else saw_block = 1'b1;
          if (int'(a_level) > max_lvl) max_lvl = int'(a_level);
          @(negedge clock);
        end
        a_valid = 1'b0;
      end
      begin
        wait_low(1'b0, 20, found3);
        for (int n = 0; n < 17; n++) begin
          recv(1'b0, rd3, rok3, rdt3);
          rx_q.push_back(rd3);
          if (!rok3 || rdt3 != 40) ok3_all = 1'b0;
        end
      end
    join
    check("t3_start_seen", found3,  1);
    check("t3_max_level",  max_lvl, 16);
    check("t3_ready_drop", saw_block, 1);
    check("t3_accepted",   acc_q.size(), 17);
    check("t3_frames_ok",  ok3_all, 1);
    for (int n = 0; n < 17; n++) begin
      check($sformatf("t3_byte%0d", n), rx_q[n], 8'(32 + n));
    end
    check("t3_busy_end", a_busy, 0);
    check("t3_tx_idle",  a_tx,   1);

    // Reset during DATA bit 3 of 0xF0 with 5 bytes queued
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1;
      a_data  = (i == 0) ? 8'hF0 : 8'(i);
      @(negedge clock);
    end
    a_valid = 1'b0;
    check("t4_queued", a_level, 5);
    repeat (13) @(negedge clock);
    check("t4_bit3_low", a_tx, 0);
    #2 reset = 1'b1;
    #1;
    check("t4_async_tx",    a_tx,    1);
    check("t4_async_level", a_level, 0);
    check("t4_async_ready", a_ready, 0);
    check("t4_async_busy",  a_busy,  0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("t4_rel_tx",    a_tx,    1);
    check("t4_rel_ready", a_ready, 1);
    a_valid = 1'b1; a_data = 8'h81;
    @(negedge clock);
    a_valid = 1'b0;
    @(negedge clock);
    recv(1'b0, rd, rok, rdt);
    check("t4_byte",   rd,     8'h81);
    check("t4_frame",  rok,    1);
    check("t4_done",   rdt,    40);
    repeat (3) @(negedge clock);
    check("t4_no_leftover", a_busy, 0);

    // Two stop bits: 0x96 then 0x5A chained
    b_valid = 1'b1; b_data = 8'h96;
    @(negedge clock);
    b_data = 8'h5A;
    @(negedge clock);
    b_valid = 1'b0;
    recv(1'b1, rd, rok, rdt);
    recv(1'b1, rd2, rok2, rdt2);
    check("t5_byte0",  rd,   8'h96);
    check("t5_byte1",  rd2,  8'h5A);
    check("t5_frame0", rok,  1);
    check("t5_frame1", rok2, 1);
    check("t5_done0",  rdt,  44);
    check("t5_done1",  rdt2, 44);
    check("t5_busy_end", b_busy, 0);
    check("t5_tx_idle",  b_tx,   1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
